// File: rtl/ahbl_apb_bridge_multi.sv
// AHB-Lite slave to APB3 master bridge with slot decode,
// PREADY wait states, optional PREADY timeout and error responses.
module ahbl_apb_bridge_multi #(
    parameter int NUM_SLAVES = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int SLOT_LSB   = 8,
    parameter int TIMEOUT    = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic                  HWRITE,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TLAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        IDLE, CAPTURE, SETUP, ACCESS, ERR1, ERR2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    write_q;
    logic [3:0]              slot_q;
    logic [CW-1:0]           cnt;
    logic                    accept;
    logic [3:0]              slot_in;
    logic                    slot_ok;
    logic                    timed_out;
    logic [NUM_SLAVES-1:0]   sel_dec;
    logic                    unused_ok;

    assign accept    = HSEL & HTRANS[1] & HREADYIN;
    assign slot_in   = HADDR[SLOT_LSB+3:SLOT_LSB];
    assign slot_ok   = {1'b0, slot_in} < 5'(NUM_SLAVES);
    assign timed_out = (TIMEOUT > 0) && (cnt == TLAST);
    assign unused_ok = ^{HSIZE, HTRANS[0]};

    always_comb begin
        sel_dec = '0;
        for (int i = 0; i < NUM_SLAVES; i++)
            sel_dec[i] = (slot_q == 4'(i));
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            cnt       <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            slot_q    <= '0;
        end else begin
            unique case (state)
                IDLE, ERR2: begin
                    state     <= IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    if (accept) begin
                        addr_q    <= HADDR;
                        write_q   <= HWRITE;
                        slot_q    <= slot_in;
                        HREADYOUT <= 1'b0;
                        // unpopulated slots never touch the APB side
                        if (slot_ok) begin
                            state <= CAPTURE;
                        end else begin
                            state <= ERR1;
                            HRESP <= 1'b1;
                        end
                    end
                end
                CAPTURE: begin
                    if (write_q) PWDATA <= HWDATA;
                    PSEL   <= sel_dec;
                    PADDR  <= addr_q;
                    PWRITE <= write_q;
                    state  <= SETUP;
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY || timed_out) begin
                        PSEL    <= '0;
                        PENABLE <= 1'b0;
                        cnt     <= '0;
                        if (PREADY && !PSLVERR) begin
                            state     <= IDLE;
                            HREADYOUT <= 1'b1;
                            if (!write_q) HRDATA <= PRDATA;
                        end else begin
                            state <= ERR1;
                            HRESP <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR1: begin
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b1;
                    state     <= ERR2;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ahbl_apb_bridge_multi.sv
// Directed bench for ahbl_apb_bridge_multi: 4 slots, timeout of 8.
module tb_ahbl_apb_bridge_multi;
    localparam int NS = 4;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic          HWRITE;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [31:0]   HWDATA;
    logic          HREADYIN;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [NS-1:0] PSEL;
    logic [31:0]   PADDR;
    logic          PWRITE;
    logic          PENABLE;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;

    int compared = 0;
    int mism = 0;
    int low, pen;
    logic [NS-1:0] sel;

    ahbl_apb_bridge_multi #(
        .NUM_SLAVES(NS), .ADDR_WIDTH(32), .SLOT_LSB(8), .TIMEOUT(8)
    ) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HREADYIN(HREADYIN), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .HRDATA(HRDATA), .PSEL(PSEL), .PADDR(PADDR),
        .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // waits = ACCESS cycles with PREADY low before ready; -1 = never ready
    task automatic xfer(input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input int waits,
                        input logic err, output int lo, output int pe,
                        output logic [NS-1:0] sl);
        int acc;
        lo = 0; pe = 0; sl = '0; acc = 0;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = addr;
        step();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = wdata;
        for (int i = 0; i < 40; i++) begin
            if (HREADYOUT) break;
            lo++;
            sl |= PSEL;
            chk("onehot", 32'($onehot0(PSEL)), 32'd1);
            if (PENABLE) begin pe++; acc++; end
            PREADY  = PENABLE && (waits >= 0) && (acc == waits + 1);
            PSLVERR = PREADY && err;
            step();
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0;
        HTRANS = 2'b00; HSIZE = 3'b010; HWDATA = '0; HREADYIN = 1'b1;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        step(); step();
        chk("rst_hready", HREADYOUT, 1);
        chk("rst_hresp", HRESP, 0);
        chk("rst_hrdata", HRDATA, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pwdata", PWDATA, 0);
        HRESET = 1'b0;
        step();
        chk("idle_hready", HREADYOUT, 1);

        // write slot 3, PREADY high
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h304;
        step();
        chk("w1_cap_hready", HREADYOUT, 0);
        chk("w1_cap_psel", PSEL, 0);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = 32'hA5A5_0001;
        step();
        chk("w1_set_psel", PSEL, 4'b1000);
        chk("w1_set_pen", PENABLE, 0);
        chk("w1_set_paddr", PADDR, 32'h304);
        chk("w1_set_pwrite", PWRITE, 1);
        chk("w1_set_pwdata", PWDATA, 32'hA5A5_0001);
        chk("w1_set_hready", HREADYOUT, 0);
        PREADY = 1'b1;
        step();
        chk("w1_acc_pen", PENABLE, 1);
        chk("w1_acc_psel", PSEL, 4'b1000);
        chk("w1_acc_hready", HREADYOUT, 0);
        step();
        PREADY = 1'b0;
        chk("w1_done_hready", HREADYOUT, 1);
        chk("w1_done_hresp", HRESP, 0);
        chk("w1_done_psel", PSEL, 0);
        chk("w1_done_pen", PENABLE, 0);

        // read slot 1 with 3 wait cycles
        PRDATA = 32'h1234_5678;
        xfer(1'b0, 32'h104, 32'hFFFF_FFFF, 3, 1'b0, low, pen, sel);
        chk("r2_low", low, 6);
        chk("r2_pen", pen, 4);
        chk("r2_sel", sel, 4'b0010);
        chk("r2_hrdata", HRDATA, 32'h1234_5678);
        chk("r2_hresp", HRESP, 0);
        chk("r2_pwdata_kept", PWDATA, 32'hA5A5_0001);
        PRDATA = 32'h0BAD_0BAD;
        xfer(1'b1, 32'h008, 32'h0000_0055, 0, 1'b0, low, pen, sel);
        chk("w3_low", low, 3);
        chk("w3_sel", sel, 4'b0001);
        chk("w3_hrdata_kept", HRDATA, 32'h1234_5678);

        // read with PSLVERR
        PRDATA = 32'hDEAD_BEEF;
        xfer(1'b0, 32'h104, 32'h0, 0, 1'b1, low, pen, sel);
        chk("e4_low", low, 4);
        chk("e4_pen", pen, 1);
        chk("e4_err2_hresp", HRESP, 1);
        chk("e4_hrdata_kept", HRDATA, 32'h1234_5678);
        step();
        chk("e4_idle_hresp", HRESP, 0);
        chk("e4_idle_hready", HREADYOUT, 1);

        // unpopulated slot 5
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h500;
        step();
        HSEL = 1'b0; HTRANS = 2'b00;
        chk("u5_t1_hready", HREADYOUT, 0);
        chk("u5_t1_hresp", HRESP, 1);
        chk("u5_t1_psel", PSEL, 0);
        step();
        chk("u5_t2_hready", HREADYOUT, 1);
        chk("u5_t2_hresp", HRESP, 1);
        chk("u5_t2_psel", PSEL, 0);
        step();
        chk("u5_idle_hresp", HRESP, 0);

        // PREADY stuck low: timeout after 8 ACCESS cycles
        xfer(1'b0, 32'h204, 32'h0, -1, 1'b0, low, pen, sel);
        chk("t6_low", low, 11);
        chk("t6_pen", pen, 8);
        chk("t6_sel", sel, 4'b0100);
        chk("t6_hresp", HRESP, 1);
        step();
        xfer(1'b1, 32'h204, 32'h0000_0077, 0, 1'b0, low, pen, sel);
        chk("t6_next_low", low, 3);
        chk("t6_next_hresp", HRESP, 0);
        chk("t6_next_pwdata", PWDATA, 32'h0000_0077);

        // back-to-back writes, reset during second ACCESS
        xfer(1'b1, 32'h100, 32'h0000_0011, 0, 1'b0, low, pen, sel);
        chk("b7_low", low, 3);
        chk("b7_sel", sel, 4'b0010);
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h208;
        step();
        chk("b7_b2b_hready", HREADYOUT, 0);
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = 32'h0000_0022;
        step();
        chk("b7_set_psel", PSEL, 4'b0100);
        step();
        chk("b7_acc_pen", PENABLE, 1);
        #3 HRESET = 1'b1;
        #1;
        chk("b7_rst_psel", PSEL, 0);
        chk("b7_rst_pen", PENABLE, 0);
        chk("b7_rst_paddr", PADDR, 0);
        chk("b7_rst_pwdata", PWDATA, 0);
        chk("b7_rst_hready", HREADYOUT, 1);
        chk("b7_rst_hresp", HRESP, 0);
        chk("b7_rst_hrdata", HRDATA, 0);
        #2 HRESET = 1'b0;
        PREADY = 1'b1; PSLVERR = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b7_post_hready", HREADYOUT, 1);
            chk("b7_post_hresp", HRESP, 0);
            chk("b7_post_pen", PENABLE, 0);
        end
        PREADY = 1'b0; PSLVERR = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mism);
        $finish;
    end
endmodule

// File: doc/ahbl_apb_bridge_multi.md
Name: ahbl_apb_bridge_multi

Overview:
- Parametrised AHB-Lite slave to APB3 master bridge for bus-functional test benches and small peripheral subsystems.
- Decodes a configurable number of APB slots from the AHB address.
- Supports PREADY wait states and maps PSLVERR to a two-cycle AHB ERROR response.
- Adds an optional PREADY timeout and an ERROR response for unpopulated slots. Sits between the AHB-Lite master/BFM and the APB peripherals.

Parameters:
- NUM_SLAVES, 16, number of PSEL lines, 1..16
- ADDR_WIDTH, 32, HADDR/PADDR width
- SLOT_LSB, 8, lowest HADDR bit of the 4-bit slot index (slot = HADDR[SLOT_LSB+3:SLOT_LSB])
- TIMEOUT, 0, max ACCESS cycles waiting for PREADY; 0 = no timeout

Ports:
- HCLK  in  1  bridge clock
- HRESET  in  1  reset; the block uses one clock, HCLK; reset HRESET is asynchronous and active-high
- HSEL  in  1  AHB slave select
- HADDR  in  ADDR_WIDTH  AHB address
- HWRITE  in  1  AHB write
- HTRANS  in  2  AHB transfer type
- HSIZE  in  3  AHB size, ignored
- HWDATA  in  32  AHB write data
- HREADYIN  in  1  AHB bus ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  1 = ERROR
- HRDATA  out  32  read data
- PSEL  out  NUM_SLAVES  one-hot APB select
- PADDR  out  ADDR_WIDTH  APB address
- PWRITE  out  1  APB write
- PENABLE  out  1  APB enable
- PWDATA  out  32  APB write data
- PRDATA  in  32  APB read data, from the selected slave (external mux)
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB error

Behaviour:
- Reset values (async, immediate, from any state):
  - state = IDLE
  - PSEL = 0, PENABLE = 0, PADDR = 0, PWRITE = 0, PWDATA = 0
  - HREADYOUT = 1, HRESP = 0, HRDATA = 0
  - timeout counter = 0
- Transfer accept condition: HSEL & HTRANS[1] & HREADYIN on a rising edge while in IDLE or ERR2.
  - On accept, register HADDR, HWRITE and the slot index.
  - IDLE/BUSY HTRANS or HSEL = 0: no action, OKAY with zero wait.
- States and transitions:
  - IDLE: HREADYOUT = 1, HRESP = 0.
    - Accept with slot < NUM_SLAVES -> CAPTURE.
    - Accept with slot >= NUM_SLAVES -> ERR1; no APB activity occurs.
  - CAPTURE: HREADYOUT = 0. Register HWDATA into PWDATA (writes only; reads leave PWDATA unchanged) -> SETUP.
  - SETUP: PSEL[slot] = 1, PENABLE = 0, PADDR and PWRITE from the registers -> ACCESS.
  - ACCESS: PSEL[slot] = 1, PENABLE = 1; the timeout counter increments each cycle with PREADY = 0.
    - PREADY = 1 & PSLVERR = 0 -> IDLE. On reads, HRDATA <= PRDATA on the same edge.
    - PREADY = 1 & PSLVERR = 1 -> ERR1. HRDATA is unchanged.
    - TIMEOUT > 0 and counter == TIMEOUT-1 with PREADY = 0 -> ERR1.
    - PSEL and PENABLE drop to 0 on leaving ACCESS. Counter clears on leaving ACCESS.
  - ERR1: HREADYOUT = 0, HRESP = 1 -> ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1.
    - Accepts a new transfer as IDLE does, to CAPTURE or ERR1.
    - Otherwise -> IDLE.
- Latency: address phase at edge T; HREADYOUT is low for cycles T+1..T+3 plus N PREADY wait cycles; OKAY completes at T+4+N.
- Error latency: PSLVERR or timeout gives ERR1/ERR2 after the final ACCESS; an unpopulated slot gives ERR1 at T+1 and ERR2 at T+2.
- Back-to-back: a transfer accepted in the IDLE completion cycle proceeds with no extra idle cycle.
- Output stability:
  - PSEL, PADDR, PWRITE and PWDATA are stable through SETUP and ACCESS.
  - PSEL is always one-hot or zero.
  - HRDATA holds its last read value across writes and errors.
- Reset asserted mid-ACCESS: APB signals drop asynchronously. No completion or error is generated after release.

Test Plan:
- Write 0xA5A5_0001 to HADDR 0x0000_0304, PREADY tied high -> PSEL = 0x0008, PADDR = 0x304, PWDATA = 0xA5A5_0001. SETUP is 1 cycle, ACCESS is 1 cycle, HREADYOUT is low for exactly 3 cycles, HRESP = 0.
- Read HADDR 0x0000_0104, PRDATA = 0x1234_5678, PREADY low for 3 ACCESS cycles -> HREADYOUT is low for 6 cycles. HRDATA = 0x1234_5678 in the completion cycle and stays there through a following write.
- Read with PSLVERR = 1 at PREADY -> HRESP = 1 with HREADYOUT 0 then 1 over two cycles. HRDATA is unchanged.
- NUM_SLAVES = 4, access HADDR 0x0000_0500 -> PSEL never asserts; two-cycle ERROR response at T+1/T+2.
- TIMEOUT = 8, PREADY stuck low -> PENABLE is high for exactly 8 cycles, then a two-cycle ERROR response. The next transfer completes normally.
- Back-to-back writes to slots 1 and 2, with HRESET pulsed during the second ACCESS -> all outputs reach their reset values in the same cycle, and no ERROR or OKAY completion follows after release.
